// File: rtl/design67_15_45_top.sv
// Capture / accumulate / rotate-XOR pipeline: out is ROTL(r1, r1[4:0]) ^ acc, registered.
// Two-edge latency from in to out; all state clears asynchronously on rst low.
module design67_15_45_top (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in,
    output logic [31:0] out
);

    logic [31:0] r1_q, r1_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] outr_q, outr_d;
    logic [4:0]  rot_amt;
    logic [63:0] rot_dbl;
    logic [31:0] rot_val;

    // Shifting a doubled copy gives the circular rotate without a mux tree per amount.
    always_comb begin
        rot_amt = r1_q[4:0];
        rot_dbl = {r1_q, r1_q} << rot_amt;
        rot_val = rot_dbl[63:32];
    end

    always_comb begin
        r1_d   = in;
        acc_d  = acc_q + r1_q;
        outr_d = rot_val ^ acc_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r1_q   <= 32'h0;
            acc_q  <= 32'h0;
            outr_q <= 32'h0;
        end else begin
            r1_q   <= r1_d;
            acc_q  <= acc_d;
            outr_q <= outr_d;
        end
    end

    assign out = outr_q;

endmodule

// File: tb/tb_design67_15_45_top.sv
// Directed and random checks of design67_15_45_top against hand values and a loop-rotate model.
module tb_design67_15_45_top;

    logic        clk;
    logic        rst;
    logic [31:0] din;
    logic [31:0] dout;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_r1, m_acc, m_out;

    design67_15_45_top dut (
        .clk (clk),
        .rst (rst),
        .in  (din),
        .out (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_rotl(input logic [31:0] x, input int n);
        logic [31:0] y;
        y = x;
        for (int i = 0; i < n; i++) y = {y[30:0], y[31]};
        return y;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One rising edge; model advances with pre-edge values, then sample 1 time unit later.
    task automatic tick();
        logic [31:0] nxt_out;
        @(posedge clk);
        nxt_out = ref_rotl(m_r1, int'(m_r1[4:0])) ^ m_acc;
        m_acc   = m_acc + m_r1;
        m_r1    = din;
        m_out   = nxt_out;
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        m_r1  = '0;
        m_acc = '0;
        m_out = '0;
        #1;
        check("reset_async", dout, 32'h0);
        tick();
        tick();
        check("reset_hold", dout, 32'h0);
    endtask

    initial begin
        rst = 1'b0;
        din = 32'h0;
        m_r1 = '0; m_acc = '0; m_out = '0;
        #2;
        check("reset_state", dout, 32'h0);

        // All-zero input stays zero.
        do_reset();
        din = 32'h0;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("zero_hold", dout, 32'h0);
        end

        // Constant 1: out = 0, 2, 3 then keeps changing.
        do_reset();
        din = 32'h1;
        rst = 1'b1;
        tick(); check("ones_e1", dout, 32'h0);
        tick(); check("ones_e2", dout, 32'h2);
        tick(); check("ones_e3", dout, 32'h3);
        tick(); check("ones_e4", dout, 32'h0);  // rotl(1,1)^2

        // Rotate by 31 equals rotate right by 1.
        do_reset();
        din = 32'h8000001F;
        rst = 1'b1;
        tick(); check("rot31_e1", dout, 32'h0);
        din = 32'h0;
        tick(); check("rot31_e2", dout, 32'hC000000F);

        // Accumulator wrap with carry dropped.
        do_reset();
        din = 32'hFFFFFFFF;
        rst = 1'b1;
        tick(); check("wrap_e1", dout, 32'h0);
        din = 32'h1;
        tick(); check("wrap_e2", dout, 32'hFFFFFFFF);
        tick(); check("wrap_e3", dout, 32'hFFFFFFFD);
        tick(); check("wrap_e4", dout, 32'h2);
        tick(); check("wrap_e5", dout, 32'h3);
        check("wrap_model", dout, m_out);

        // Mid-operation asynchronous reset between edges.
        din = 32'h12345678;
        tick(); tick();
        check("pre_async_model", dout, m_out);
        check("pre_async_nonzero", 32'(dout != 32'h0), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("async_clear", dout, 32'h0);
        m_r1 = '0; m_acc = '0; m_out = '0;
        tick();
        check("async_hold", dout, 32'h0);
        rst = 1'b1;
        din = 32'h0;
        tick(); check("post_reset_first", dout, 32'h0);
        tick(); check("post_reset_no_retain", dout, 32'h0);

        // Random words, each held for two edges.
        do_reset();
        rst = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            din = $urandom;
            tick();
            tick();
            check("random", dout, m_out);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/design67_15_45_top.md
DESIGN67_15_45_TOP -- requirements
Module: design67_15_45_top

Interface
REQ-001 SHALL have no parameters; all widths fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (rst=0 resets, rst=1 runs).
REQ-004 in  input  32  data word, sampled every rising clk edge, no handshake.
REQ-005 out  output  32  registered result word, driven directly from a flop.

Function
REQ-006 SHALL hold three 32-bit registers: R1 (input capture), ACC (accumulator), OUTR (drives out).
REQ-007 Every rising clk edge with rst=1, R1 SHALL load in.
REQ-008 On the same edge, ACC SHALL load ACC + R1, using pre-edge values, modulo 2^32 (carry discarded).
REQ-009 On the same edge, OUTR SHALL load ROTL(R1, R1[4:0]) XOR ACC, using pre-edge R1 and ACC.
REQ-010 ROTL(x,n) SHALL be a 32-bit left circular rotate by n (0..31).
  - n=0: x unchanged.
  - n=31: equals rotate-right by 1.
REQ-011 Latency from in to out SHALL be 2 rising edges: in sampled at edge k appears in out after edge k+1.
REQ-012 ACC SHALL include R1 one edge after R1 captures it, so out at edge k+1 excludes the word captured at edge k.
REQ-013 out SHALL be purely a register output, with no combinational path from in or rst to out except the asynchronous clear.
REQ-014 Holding in constant SHALL produce a changing out, because ACC keeps accumulating.
REQ-015 There SHALL be no enable, stall or valid; the design updates every cycle.
REQ-016 The design SHALL be deterministic with no X propagation after reset.
REQ-017 A post-route netlist of this block SHALL be cycle-identical to the RTL on out at every sample point.

Reset
REQ-018 When rst=0, R1, ACC and OUTR SHALL clear to 0 immediately, without waiting for clk.
REQ-019 While rst=0, the registers SHALL stay 0 regardless of clk and in.
REQ-020 On the first rising edge after rst returns to 1, normal updates SHALL resume (REQ-007..009).
REQ-021 On that first edge, out SHALL load ROTL(0,0)^0 = 0.
REQ-022 Reset asserted mid-operation SHALL discard all accumulated state; there is no partial retention.

Verification
REQ-023 Reset, in=0, then release and hold in=0 for 10 edges -> out = 0 throughout.
REQ-024 Release reset with in=32'h00000001 held -> out after edges 1, 2, 3 = 0, 32'h00000002, 32'h00000003 (ACC = 0, 1, 2).
REQ-025 Release reset with in=32'h8000001F applied before edge 1, in=0 afterwards -> out after edge 2 = 32'hC000000F.
REQ-026 Preload ACC=32'hFFFFFFFF (via in=32'hFFFFFFFF for one edge, then in=32'h00000001) -> ACC wraps to 0 with carry dropped; the out sequence matches a reference model.
REQ-027 Drive rst=0 between clock edges while out≠0 -> out = 0 within the same time step, before the next clk edge.
REQ-028 Random test: after reset, 1000 random in words, each held for 2 edges -> out matches a cycle-accurate model of REQ-007..010 after every second edge.
